// File: rtl/pwm_capture.sv
// PWM period / high-time / duty-cycle capture with stuck-line timeout.
// Duty is computed by a 7-cycle restoring divider after each measurement.
module pwm_capture #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [6:0]       duty,
    output logic             valid,
    output logic             stuck,
    output logic             overrun,
    output logic [9:0]       LEDR
);

    localparam int DW = CNT_W + 7;
    localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CMAX = '1;

    typedef enum logic {WAIT_EDGE, MEASURE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic [CNT_W-1:0] r_pcnt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_lat_p;
    logic [CNT_W-1:0] r_lat_h;
    logic [DW-1:0]    r_rem;
    logic [DW-1:0]    r_dsh;
    logic [6:0]       r_q;
    logic [2:0]       r_step;
    logic             r_busy;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic [6:0]       r_duty;
    logic             r_valid;
    logic             r_stuck;
    logic             r_overrun;
    logic [9:0]       r_ledr;

    logic             w_edge;
    logic             w_meas;
    logic             w_latch;
    logic             w_drop;
    logic             w_tmo;
    logic             w_ge;
    logic [DW-1:0]    w_rem_nxt;
    logic [6:0]       w_q;
    logic             w_done;

    function automatic logic [9:0] f_bar(input logic [6:0] d);
        logic [9:0] bar;
        for (int k = 0; k < 10; k++) begin
            bar[k] = (d > 7'(10 * k));
        end
        return bar;
    endfunction

    assign w_edge    = r_sync2 & ~r_prev;
    assign w_meas    = (r_state == MEASURE);
    assign w_latch   = w_edge & w_meas & ~r_busy;
    assign w_drop    = w_edge & w_meas & r_busy;
    // An edge coinciding with the timeout wins and is measured normally
    assign w_tmo     = w_meas & ~w_edge & (r_pcnt == TMO);
    assign w_ge      = (r_rem >= r_dsh);
    assign w_rem_nxt = w_ge ? (r_rem - r_dsh) : r_rem;
    assign w_q       = {r_q[5:0], w_ge};
    assign w_done    = r_busy & (r_step == 3'd0) & ~w_drop & ~w_tmo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= WAIT_EDGE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            WAIT_EDGE: if (w_edge) w_state_nxt = MEASURE;
            MEASURE:   if (w_tmo)  w_state_nxt = WAIT_EDGE;
            default:   w_state_nxt = WAIT_EDGE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= pwm_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // The edge cycle itself is cycle 1 of the new interval
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pcnt <= '0;
            r_hcnt <= '0;
        end else if (w_edge) begin
            r_pcnt <= CNT_W'(1);
            r_hcnt <= CNT_W'(1);
        end else if (w_meas) begin
            if (r_pcnt != CMAX) r_pcnt <= r_pcnt + CNT_W'(1);
            if (r_sync2 && r_hcnt != CMAX) r_hcnt <= r_hcnt + CNT_W'(1);
        end else begin
            r_pcnt <= '0;
            r_hcnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy  <= 1'b0;
            r_step  <= '0;
            r_rem   <= '0;
            r_dsh   <= '0;
            r_q     <= '0;
            r_lat_p <= '0;
            r_lat_h <= '0;
        end else if (w_latch) begin
            r_busy  <= 1'b1;
            r_step  <= 3'd6;
            r_rem   <= DW'(r_hcnt) * DW'(100);
            r_dsh   <= {1'b0, r_pcnt, 6'b0};
            r_q     <= '0;
            r_lat_p <= r_pcnt;
            r_lat_h <= r_hcnt;
        end else if (w_drop || w_tmo) begin
            r_busy <= 1'b0;
        end else if (r_busy) begin
            r_rem  <= w_rem_nxt;
            r_dsh  <= r_dsh >> 1;
            r_q    <= w_q;
            r_step <= r_step - 3'd1;
            if (r_step == 3'd0) r_busy <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_period  <= '0;
            r_high    <= '0;
            r_duty    <= '0;
            r_valid   <= 1'b0;
            r_stuck   <= 1'b0;
            r_overrun <= 1'b0;
            r_ledr    <= '0;
        end else begin
            r_valid <= 1'b0;
            if (w_drop) r_overrun <= 1'b1;
            if (w_edge) r_stuck <= 1'b0;
            if (w_done) begin
                r_period <= r_lat_p;
                r_high   <= r_lat_h;
                r_duty   <= w_q;
                r_ledr   <= f_bar(w_q);
                r_valid  <= 1'b1;
            end else if (w_tmo) begin
                r_period <= '0;
                r_high   <= '0;
                r_duty   <= r_sync2 ? 7'd100 : 7'd0;
                r_ledr   <= r_sync2 ? 10'h3FF : 10'h000;
                r_valid  <= 1'b1;
                r_stuck  <= 1'b1;
            end
        end
    end

    assign period    = r_period;
    assign high_time = r_high;
    assign duty      = r_duty;
    assign valid     = r_valid;
    assign stuck     = r_stuck;
    assign overrun   = r_overrun;
    assign LEDR      = r_ledr;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: measurement, overrun, timeout, reset.
module tb_pwm_capture;

    logic        clk;
    logic        rst;
    logic        pwm_in;
    logic [15:0] period;
    logic [15:0] high_time;
    logic [6:0]  duty;
    logic        valid;
    logic        stuck;
    logic        overrun;
    logic [9:0]  LEDR;

    int errors = 0;
    int checks = 0;
    int vcnt;
    int vpos;
    int tv = 0;
    int tv0;
    int first;
    int clr;

    pwm_capture #(.CNT_W(16), .TIMEOUT(1000)) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .period    (period),
        .high_time (high_time),
        .duty      (duty),
        .valid     (valid),
        .stuck     (stuck),
        .overrun   (overrun),
        .LEDR      (LEDR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (valid) tv++;
    endtask

    // One PWM period: high for h cycles, low for p-h cycles
    task automatic run(input int p, input int h);
        vcnt = 0;
        vpos = -1;
        for (int i = 0; i < p; i++) begin
            pwm_in = (i < h);
            cyc();
            if (valid) begin
                vcnt++;
                vpos = i;
            end
        end
    endtask

    task automatic reset_dut();
        rst    = 1'b0;
        pwm_in = 1'b0;
        repeat (3) cyc();
        rst = 1'b1;
        repeat (3) cyc();
    endtask

    initial begin
        rst    = 1'b0;
        pwm_in = 1'b0;
        repeat (2) cyc();
        chk("rst_period", period, 0);
        chk("rst_high", high_time, 0);
        chk("rst_duty", duty, 0);
        chk("rst_valid", valid, 0);
        chk("rst_stuck", stuck, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_ledr", LEDR, 0);
        rst = 1'b1;
        repeat (3) cyc();

        run(100, 25);
        chk("first_edge_silent", vcnt, 0);
        run(100, 25);
        chk("p100_vcnt", vcnt, 1);
        chk("p100_vpos", vpos, 9);
        chk("p100_period", period, 100);
        chk("p100_high", high_time, 25);
        chk("p100_duty", duty, 25);
        chk("p100_ledr", LEDR, 10'b0000000111);
        run(100, 25);
        chk("p100b_vpos", vpos, 9);
        chk("p100b_period", period, 100);

        run(99, 33);
        run(99, 33);
        chk("p99_period", period, 99);
        chk("p99_high", high_time, 33);
        chk("p99_duty", duty, 33);
        chk("p99_ledr", LEDR, 10'b0000001111);
        run(200, 199);
        run(100, 25);
        chk("p200_period", period, 200);
        chk("p200_high", high_time, 199);
        chk("p200_duty", duty, 99);
        chk("p200_ledr", LEDR, 10'b1111111111);

        run(50, 20);
        run(50, 20);
        chk("p50_duty", duty, 40);
        chk("p50_ledr", LEDR, 10'b0000001111);
        chk("p50_no_overrun", overrun, 0);
        tv0 = tv;
        repeat (10) run(6, 3);
        chk("ovr_set", overrun, 1);
        chk("ovr_no_valid", tv - tv0, 0);
        chk("ovr_keep_period", period, 50);
        chk("ovr_keep_high", high_time, 20);
        chk("ovr_keep_duty", duty, 40);
        repeat (3) run(50, 20);
        chk("resume_vpos", vpos, 9);
        chk("resume_period", period, 50);
        chk("resume_duty", duty, 40);
        chk("resume_overrun", overrun, 1);

        run(40, 10);
        chk("pre_rst_period", period, 50);
        pwm_in = 1'b1;
        repeat (5) cyc();
        rst    = 1'b0;
        pwm_in = 1'b0;
        #1;
        chk("midrst_period", period, 0);
        chk("midrst_high", high_time, 0);
        chk("midrst_duty", duty, 0);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_ledr", LEDR, 0);
        tv0 = tv;
        repeat (2) cyc();
        rst = 1'b1;
        repeat (15) cyc();
        chk("midrst_no_valid", tv - tv0, 0);
        run(40, 10);
        chk("postrst_silent", vcnt, 0);
        run(40, 10);
        chk("postrst_vcnt", vcnt, 1);
        chk("postrst_period", period, 40);
        chk("postrst_duty", duty, 25);

        reset_dut();
        tv0   = tv;
        first = -1;
        for (int i = 0; i < 1100; i++) begin
            pwm_in = (i < 5);
            cyc();
            if (stuck && first < 0) first = i;
        end
        chk("tlow_when", first, 1002);
        chk("tlow_valids", tv - tv0, 1);
        chk("tlow_stuck", stuck, 1);
        chk("tlow_duty", duty, 0);
        chk("tlow_ledr", LEDR, 0);
        chk("tlow_period", period, 0);

        tv0   = tv;
        first = -1;
        clr   = -1;
        for (int i = 0; i < 1100; i++) begin
            pwm_in = 1'b1;
            cyc();
            if (!stuck && clr < 0) clr = i;
            if (stuck && clr >= 0 && first < 0) first = i;
        end
        chk("thigh_clear_at", clr, 2);
        chk("thigh_when", first, 1002);
        chk("thigh_valids", tv - tv0, 1);
        chk("thigh_duty", duty, 100);
        chk("thigh_ledr", LEDR, 10'h3FF);
        chk("thigh_high", high_time, 0);

        pwm_in = 1'b0;
        repeat (3) cyc();
        run(20, 10);
        chk("unstuck", stuck, 0);
        chk("unstuck_silent", vcnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
